// File: rtl/vga_pkg.sv
// Shared VGA constants, RGB222 colour type and the TinyVGA PMOD bit packing.
package vga_pkg;

  // 640x480@60 (25.175 MHz nominal) timing
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned PMOD_R1 = 0;
  localparam int unsigned PMOD_G1 = 1;
  localparam int unsigned PMOD_B1 = 2;
  localparam int unsigned PMOD_VS = 3;
  localparam int unsigned PMOD_R0 = 4;
  localparam int unsigned PMOD_G0 = 5;
  localparam int unsigned PMOD_B0 = 6;
  localparam int unsigned PMOD_HS = 7;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb222_t;

  // Sync levels are passed as final pin levels (polarity already applied).
  function automatic logic [7:0] pmod_pack(input logic hs, input logic vs, input rgb222_t c);
    logic [7:0] p;
    p          = '0;
    p[PMOD_HS] = hs;
    p[PMOD_VS] = vs;
    p[PMOD_R1] = c.r[1];
    p[PMOD_G1] = c.g[1];
    p[PMOD_B1] = c.b[1];
    p[PMOD_R0] = c.r[0];
    p[PMOD_G0] = c.g[0];
    p[PMOD_B0] = c.b[0];
    return p;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One VGA axis: position counter with active-region and sync-level decode.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned FP     = VGA_H_FP,
  parameter int unsigned SYNC   = VGA_H_SYNC,
  parameter int unsigned BP     = VGA_H_BP,
  parameter bit          POL    = 1'b0,
  parameter int unsigned W      = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         in_active_c,
  output logic         sync_c,
  output logic         wrap_c
);

  localparam int unsigned TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam int unsigned SYNC_START = ACTIVE + FP;
  localparam int unsigned SYNC_END   = ACTIVE + FP + SYNC;

  logic [W-1:0] count_q, count_d;
  logic [31:0]  count_wide;
  logic         sync_on;

  // Decode in 32 bits so a sync end equal to 2^W cannot truncate to zero.
  always_comb begin
    count_wide  = 32'(count_q);
    wrap_c      = step && (count_wide == TOTAL - 1);
    count_d     = count_q;
    if (step) begin
      count_d = wrap_c ? '0 : count_q + W'(1);
    end
    in_active_c = count_wide < ACTIVE;
    sync_on     = (count_wide >= SYNC_START) && (count_wide < SYNC_END);
    sync_c      = sync_on ? POL : ~POL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vga_pmod_timing.sv
// Parametrised VGA timing generator with registered TinyVGA PMOD output stage.
module vga_pmod_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
  parameter int unsigned H_FP      = VGA_H_FP,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BP      = VGA_H_BP,
  parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
  parameter int unsigned V_FP      = VGA_V_FP,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BP      = VGA_V_BP,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned PIX_DIV   = 1,
  parameter int unsigned X_W       = 10,
  parameter int unsigned Y_W       = 10,
  parameter int unsigned FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         pix_r,
  input  logic [1:0]         pix_g,
  input  logic [1:0]         pix_b,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic               active,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame,
  output logic [7:0]         vga_pmod
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam rgb222_t     BLACK   = '0;
  localparam logic [7:0]  PMOD_IDLE = pmod_pack(~HSYNC_POL, ~VSYNC_POL, BLACK);

  if (PIX_DIV < 1) begin : g_bad_div
    $error("vga_pmod_timing: PIX_DIV must be >= 1");
  end
  if ((64'd1 << X_W) < 64'(H_TOTAL)) begin : g_bad_xw
    $error("vga_pmod_timing: X_W too narrow for H_TOTAL");
  end
  if ((64'd1 << Y_W) < 64'(V_TOTAL)) begin : g_bad_yw
    $error("vga_pmod_timing: Y_W too narrow for V_TOTAL");
  end

  logic [DIV_W-1:0]   div_q, div_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [7:0]         pmod_q, pmod_d;
  logic               tick_c;
  logic               h_active_c, h_sync_c, h_wrap_c;
  logic               v_active_c, v_sync_c, v_wrap_c;
  logic [X_W-1:0]     hcount;
  logic [Y_W-1:0]     vcount;
  rgb222_t            colour_c;

  // Pixel-clock divider; holds its phase while disabled.
  always_comb begin
    tick_c = en && (div_q == DIV_W'(PIX_DIV - 1));
    div_d  = div_q;
    if (en) begin
      div_d = tick_c ? '0 : div_q + DIV_W'(1);
    end
  end

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .POL(HSYNC_POL), .W(X_W)
  ) u_h (
    .clk        (clk),
    .rst        (rst),
    .step       (tick_c),
    .count      (hcount),
    .in_active_c(h_active_c),
    .sync_c     (h_sync_c),
    .wrap_c     (h_wrap_c)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .POL(VSYNC_POL), .W(Y_W)
  ) u_v (
    .clk        (clk),
    .rst        (rst),
    .step       (h_wrap_c),
    .count      (vcount),
    .in_active_c(v_active_c),
    .sync_c     (v_sync_c),
    .wrap_c     (v_wrap_c)
  );

  // Frame counter and PMOD stage; output falls back to idle whenever disabled.
  always_comb begin
    frame_d  = frame_q;
    pmod_d   = pmod_q;
    colour_c = BLACK;
    if (h_active_c && v_active_c) begin
      colour_c = '{r: pix_r, g: pix_g, b: pix_b};
    end
    if (v_wrap_c) begin
      frame_d = frame_q + FRAME_W'(1);
    end
    if (!en) begin
      pmod_d = PMOD_IDLE;
    end else if (tick_c) begin
      pmod_d = pmod_pack(h_sync_c, v_sync_c, colour_c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      frame_q <= '0;
      pmod_q  <= PMOD_IDLE;
    end else begin
      div_q   <= div_d;
      frame_q <= frame_d;
      pmod_q  <= pmod_d;
    end
  end

  assign x           = hcount;
  assign y           = vcount;
  assign active      = h_active_c && v_active_c;
  assign line_start  = en && (div_q == '0) && (hcount == '0);
  assign frame_start = line_start && (vcount == '0);
  assign frame       = frame_q;
  assign vga_pmod    = pmod_q;

endmodule

// File: tb/tb_vga_pmod_timing.sv
// Directed bench: default 640x480, a tiny divided mode and an inverted-polarity mode.
module tb_vga_pmod_timing;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] pix_r, pix_g, pix_b;

  always #5 clk = ~clk;

  logic [9:0] d_x, d_y;
  logic       d_act, d_ls, d_fs;
  logic [7:0] d_frame, d_pmod;

  logic [9:0] s_x, s_y;
  logic       s_act, s_ls, s_fs;
  logic [1:0] s_frame;
  logic [7:0] s_pmod;

  logic [9:0] p_x, p_y;
  logic       p_act, p_ls, p_fs;
  logic [7:0] p_frame, p_pmod;

  vga_pmod_timing u_def (
    .clk(clk), .rst(rst), .en(en), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .x(d_x), .y(d_y), .active(d_act), .line_start(d_ls), .frame_start(d_fs),
    .frame(d_frame), .vga_pmod(d_pmod)
  );

  vga_pmod_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .PIX_DIV(2), .FRAME_W(2)
  ) u_small (
    .clk(clk), .rst(rst), .en(en), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .x(s_x), .y(s_y), .active(s_act), .line_start(s_ls), .frame_start(s_fs),
    .frame(s_frame), .vga_pmod(s_pmod)
  );

  vga_pmod_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) u_pol (
    .clk(clk), .rst(rst), .en(en), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .x(p_x), .y(p_y), .active(p_act), .line_start(p_ls), .frame_start(p_fs),
    .frame(p_frame), .vga_pmod(p_pmod)
  );

  typedef struct {
    logic       en;
    logic [1:0] r, g, b;
    logic [9:0] x;
    logic       ls, fs;
    logic [7:0] pmod;
  } vec_t;

  vec_t vecs[18];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Leaves the bench at the negedge where reset is released (cycle 0 window).
  task automatic reset_all();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int d_hs_low, d_first_hs, d_ls_cnt;
  int s_hs_low, s_vs_low, s_first_vs, s_ls_cnt, s_fs_cnt;
  int p_hs_high, p_vs_high;

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    pix_r = 2'b11;
    pix_g = 2'b01;
    pix_b = 2'b10;

    // Pause/resume vectors for the default mode, one per clock from reset release.
    for (int i = 0; i < 18; i++) begin
      vecs[i].en = 1'b1;
      vecs[i].r = 2'b11; vecs[i].g = 2'b01; vecs[i].b = 2'b10;
      vecs[i].x = 10'(i);
      vecs[i].ls = 1'b0; vecs[i].fs = 1'b0;
      vecs[i].pmod = 8'hBD;
    end
    vecs[0].ls = 1'b1; vecs[0].fs = 1'b1; vecs[0].pmod = 8'h88;
    for (int i = 5; i < 15; i++) begin
      vecs[i].en   = 1'b0;
      vecs[i].x    = 10'd5;
      vecs[i].pmod = (i == 5) ? 8'hBD : 8'h88;
    end
    vecs[15].x = 10'd5; vecs[15].pmod = 8'h88;
    vecs[15].r = 2'b01; vecs[15].g = 2'b10; vecs[15].b = 2'b11;
    vecs[16].x = 10'd6; vecs[16].pmod = 8'hDE;
    vecs[17].x = 10'd7;

    repeat (2) @(negedge clk);
    check("reset_pmod_def", 32'(d_pmod), 32'h88);
    check("reset_pmod_pol", 32'(p_pmod), 32'h00);
    check("reset_x", 32'(d_x), 0);

    reset_all();
    for (int i = 0; i < 18; i++) begin
      en = vecs[i].en; pix_r = vecs[i].r; pix_g = vecs[i].g; pix_b = vecs[i].b;
      #1;
      check($sformatf("vec%0d_x", i), 32'(d_x), 32'(vecs[i].x));
      check($sformatf("vec%0d_ls", i), 32'(d_ls), 32'(vecs[i].ls));
      check($sformatf("vec%0d_fs", i), 32'(d_fs), 32'(vecs[i].fs));
      check($sformatf("vec%0d_pmod", i), 32'(d_pmod), 32'(vecs[i].pmod));
      @(negedge clk);
    end

    // Free run: sync placement and periods for all three modes.
    pix_r = 2'b11; pix_g = 2'b01; pix_b = 2'b10;
    reset_all();
    en = 1'b1;
    d_hs_low = 0; d_first_hs = -1; d_ls_cnt = 0;
    s_hs_low = 0; s_vs_low = 0; s_first_vs = -1; s_ls_cnt = 0; s_fs_cnt = 0;
    p_hs_high = 0; p_vs_high = 0;
    for (int i = 0; i < 1900; i++) begin
      #1;
      if (i < 800 && !d_pmod[7]) d_hs_low++;
      if (!d_pmod[7] && d_first_hs < 0) d_first_hs = i;
      if (i < 1600 && d_ls) d_ls_cnt++;
      if (i == 100) check("def_active_pmod", 32'(d_pmod), 32'hBD);
      if (i == 650) check("def_blank_pmod", 32'(d_pmod), 32'h88);
      if (i == 700) check("def_hsync_pmod", 32'(d_pmod), 32'h08);
      if (i == 800) begin
        check("def_line1_ls", 32'(d_ls), 1);
        check("def_line1_y", 32'(d_y), 1);
        check("def_line1_x", 32'(d_x), 0);
      end
      if (i < 196) begin
        if (!s_pmod[7]) s_hs_low++;
        if (!s_pmod[3]) s_vs_low++;
        if (!s_pmod[3] && s_first_vs < 0) s_first_vs = i;
        if (s_ls) s_ls_cnt++;
        if (s_fs) s_fs_cnt++;
      end
      if (i == 0)  check("small_x0", 32'(s_x), 0);
      if (i == 1)  check("small_x1", 32'(s_x), 0);
      if (i == 2)  check("small_x2", 32'(s_x), 1);
      if (i == 27) check("small_x27", 32'(s_x), 13);
      if (i == 28) begin
        check("small_line1_x", 32'(s_x), 0);
        check("small_line1_y", 32'(s_y), 1);
        check("small_line1_ls", 32'(s_ls), 1);
      end
      if (i > 0 && i % 196 == 0 && i <= 980) begin
        check($sformatf("small_frame_at_%0d", i), 32'(s_frame), 32'((i / 196) % 4));
        check($sformatf("small_fs_at_%0d", i), 32'(s_fs), 1);
      end
      if (i < 112) begin
        if (p_pmod[7]) p_hs_high++;
        if (p_pmod[3]) p_vs_high++;
      end
      @(negedge clk);
    end
    check("def_hs_low_per_line", 32'(d_hs_low), 96);
    check("def_first_hs_low", 32'(d_first_hs), 657);
    check("def_ls_count", 32'(d_ls_cnt), 2);
    check("small_hs_low", 32'(s_hs_low), 28);
    check("small_vs_low", 32'(s_vs_low), 28);
    check("small_first_vs", 32'(s_first_vs), 142);
    check("small_ls_count", 32'(s_ls_cnt), 7);
    check("small_fs_count", 32'(s_fs_cnt), 1);
    check("pol_hs_high", 32'(p_hs_high), 16);
    check("pol_vs_high", 32'(p_vs_high), 28);

    // Mid-frame reset must act without waiting for a clock edge.
    #1;
    check("pre_rst_x", 32'(d_x), 300);
    check("pre_rst_y", 32'(d_y), 2);
    check("pre_rst_small_frame", 32'(s_frame), 1);
    rst = 1'b1;
    #1;
    check("rst_async_pmod", 32'(d_pmod), 32'h88);
    check("rst_async_x", 32'(d_x), 0);
    check("rst_async_y", 32'(d_y), 0);
    check("rst_async_small_frame", 32'(s_frame), 0);
    check("rst_async_pol_pmod", 32'(p_pmod), 32'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_ls", 32'(d_ls), 1);
    check("release_fs", 32'(d_fs), 1);
    check("release_frame", 32'(d_frame), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_pmod_timing.md
Name: vga_pmod_timing

Overview:
Parametrised VGA timing generator and TinyVGA PMOD output stage, succeeding the fixed-mode graphics front end driven from tt_um_minesweeper.
- Generates pixel coordinates, active-video flag, line/frame strobes and a frame counter for any resolution, porch widths, sync polarities and pixel-clock divide.
- Registers externally supplied RGB222 colour together with delayed syncs onto the 8-bit PMOD bus.
- Sits between the top-level wrapper and the per-game pixel renderer.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted hsync level
- VSYNC_POL, 0, asserted vsync level
- PIX_DIV, 1, clk cycles per pixel (>=1)
- X_W, 10, x/hcount width
- Y_W, 10, y/vcount width
- FRAME_W, 8, frame counter width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- en  in  1  timing enable
- pix_r  in  2  colour for current x,y
- pix_g  in  2  colour for current x,y
- pix_b  in  2  colour for current x,y
- x  out  X_W  current hcount
- y  out  Y_W  current vcount
- active  out  1  current position is visible
- line_start  out  1  one-clk strobe, first clk of pixel h=0
- frame_start  out  1  one-clk strobe, first clk of pixel h=0, v=0
- frame  out  FRAME_W  completed-frame count, wraps
- vga_pmod  out  8  {hsync,b[0],g[0],r[0],vsync,b[1],g[1],r[1]}

Behaviour:
- Derived constants: H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters.
- Elaboration error if PIX_DIV<1, 2^X_W<H_TOTAL or 2^Y_W<V_TOTAL.
- Reset (async assert, sync release):
  - div, hcount, vcount and frame are 0.
  - vga_pmod = IDLE: bit7 = !HSYNC_POL, bit3 = !VSYNC_POL, all colour bits 0.
  - Takes effect immediately, including mid-frame.
- Pixel tick: div counts 0..PIX_DIV-1 while en=1. tick = en && div==PIX_DIV-1. With PIX_DIV=1, tick = en.
- On tick, hcount advances:
  - hcount wraps H_TOTAL-1 -> 0, and vcount advances.
  - vcount wraps V_TOTAL-1 -> 0, and frame increments modulo 2^FRAME_W.
- x = hcount and y = vcount, both combinational from the counter registers.
- active = hcount<H_ACTIVE && vcount<V_ACTIVE.
- hs_int asserted when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
- vs_int asserted when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC. vsync spans whole lines, aligned to hcount=0.
- Strobes:
  - line_start = en && div==0 && hcount==0.
  - frame_start = line_start && vcount==0.
  - Both are high in the first clk after reset release when en=1.
- Output stage, on tick: vga_pmod <= packed {hs,colour,vs,colour}.
  - Sync levels are HSYNC_POL/VSYNC_POL when asserted, inverted otherwise.
  - Colour is zeroed when !active.
  - Latency: exactly one pixel tick from x,y to the PMOD. The renderer supplies pix_* combinationally from x,y in the same clk.
- Outputs are stable between ticks.
- en=0:
  - div, hcount, vcount and frame hold.
  - Strobes are 0.
  - vga_pmod <= IDLE on the next clk.
- On en returning to 1, counting resumes from the held position with div restarting at its held value. Pixel at held x is emitted on the next tick.
- Colour inputs are ignored outside active. No other inputs affect timing.

Decomposition:
- Package vga_pkg holds:
  - 640x480@60 default timing constants;
  - PMOD bit-index constants (HS=7, VS=3, R1=0, G1=1, B1=2, R0=4, G0=5, B0=6);
  - a packing function colour+syncs -> 8-bit.
- One sub-module is natural: vga_axis_counter, parametrised by ACTIVE/FP/SYNC/BP/POL/W.
  - Inputs: step, and a wrap-out output.
  - Outputs: count, in_active, sync.
  - Instantiated once for H and once for V, with V stepped by H wrap.

Test Plan:
- Reset mid-frame (rst high at x=300,y=100, defaults) -> vga_pmod=8'h88 within same clk; x=y=frame=0 after release.
- Defaults, PIX_DIV=1, constant colour -> hsync low exactly 96 clk per 800, first low output clk is 657 after frame_start; vsync low 1600 clk per 420000.
- Small config H=8/2/2/2, V=4/1/1/1, PIX_DIV=2, FRAME_W=2 -> x steps every 2 clk; line_start period 28 clk; frame_start period 196 clk; frame counts 0,1,2,3,0.
- pix_r=2'b11, pix_g=2'b01, pix_b=2'b10, POL=0 -> vga_pmod=8'hBD during active pixels; 8'h88 in blanking outside sync; 8'h08 during hsync (only hsync asserted).
- en low at x=5 for 10 clk -> x stays 5; vga_pmod=8'h88 from next clk; no strobes; after en high, x=5 emitted, then x=6.
- HSYNC_POL=VSYNC_POL=1 -> reset/idle vga_pmod=8'h00; sync pulses drive bits 7/3 high for 96 clk / 2 lines.
